// File: rtl/imm_decode_pipe.sv
// Registered immediate decoder for the ID stage.
// One valid/ready register stage; decodes RV32/RV64 immediates and,
// optionally, RVC immediates, producing an XLEN-wide extended value,
// a format code and an illegal-encoding flag.
module imm_decode_pipe #(
    parameter int XLEN   = 64,
    parameter bit EN_RVC = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam logic [2:0] FMT_C    = 3'd7;

    localparam bit IS64 = (XLEN == 64);

    // Every raw immediate below is built as a full 32-bit value whose upper
    // bits already hold the correct fill (sign copies or zeros), so a single
    // sign-extension from bit 31 yields the right XLEN result for all formats.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v);
        return XLEN'(signed'(v));
    endfunction

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [1:0]  q;
    logic [2:0]  f;
    logic        i12;
    logic [4:0]  c_rd;

    assign ins    = in_instr;
    assign opcode = ins[6:0];
    assign q      = ins[1:0];
    assign f      = ins[15:13];
    assign i12    = ins[12];
    assign c_rd   = ins[11:7];

    // 32-bit formats
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_z = {27'b0, ins[19:15]};

    // Compressed formats
    logic [31:0] c_addi4spn, c_lw, c_ld, c_s6, c_z6, c_addi16sp, c_lui;
    logic [31:0] c_j, c_b, c_lwsp, c_ldsp, c_swsp, c_sdsp;

    assign c_addi4spn = {22'b0, ins[10:7], ins[12:11], ins[5], ins[6], 2'b0};
    assign c_lw       = {25'b0, ins[5], ins[12:10], ins[6], 2'b0};
    assign c_ld       = {24'b0, ins[6:5], ins[12:10], 3'b0};
    assign c_s6       = {{26{i12}}, i12, ins[6:2]};
    assign c_z6       = {26'b0, i12, ins[6:2]};
    assign c_addi16sp = {{22{i12}}, i12, ins[4:3], ins[5], ins[2], ins[6], 4'b0};
    assign c_lui      = {{14{i12}}, i12, ins[6:2], 12'b0};
    assign c_j        = {{20{i12}}, i12, ins[8], ins[10:9], ins[6], ins[7], ins[2],
                         ins[11], ins[5:3], 1'b0};
    assign c_b        = {{23{i12}}, i12, ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
    assign c_lwsp     = {24'b0, ins[3:2], i12, ins[6:4], 2'b0};
    assign c_ldsp     = {23'b0, ins[4:2], i12, ins[6:5], 3'b0};
    assign c_swsp     = {24'b0, ins[8:7], ins[12:9], 2'b0};
    assign c_sdsp     = {23'b0, ins[9:7], ins[12:10], 3'b0};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0]     dec_raw;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;

    // Select the raw immediate, format code and illegal flag for in_instr.
    always_comb begin
        dec_raw = 32'b0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        if (q == 2'b11) begin
            unique case (opcode)
                7'b0000011, 7'b0010011, 7'b1100111: begin
                    dec_fmt = FMT_I;
                    dec_raw = imm_i;
                end
                7'b0011011: begin
                    // OP-IMM-32 only exists on RV64
                    if (IS64) begin
                        dec_fmt = FMT_I;
                        dec_raw = imm_i;
                    end
                end
                7'b0100011: begin
                    dec_fmt = FMT_S;
                    dec_raw = imm_s;
                end
                7'b1100011: begin
                    dec_fmt = FMT_B;
                    dec_raw = imm_b;
                end
                7'b0110111, 7'b0010111: begin
                    dec_fmt = FMT_U;
                    dec_raw = imm_u;
                end
                7'b1101111: begin
                    dec_fmt = FMT_J;
                    dec_raw = imm_j;
                end
                7'b1110011: begin
                    // Only the CSR*I variants carry a zimm
                    if (ins[14]) begin
                        dec_fmt = FMT_Z;
                        dec_raw = imm_z;
                    end
                end
                default: ;
            endcase
        end else if (!EN_RVC) begin
            dec_ill = 1'b1;
        end else begin
            dec_fmt = FMT_C;
            unique case (q)
                2'b00: begin
                    unique case (f)
                        3'b000: begin
                            dec_raw = c_addi4spn;
                            dec_ill = (c_addi4spn == 32'b0);
                        end
                        3'b010, 3'b110: dec_raw = c_lw;
                        3'b001, 3'b101: dec_raw = c_ld;
                        3'b011, 3'b111: dec_raw = IS64 ? c_ld : c_lw;
                        default: ;
                    endcase
                end
                2'b01: begin
                    unique case (f)
                        3'b000, 3'b010: dec_raw = c_s6;
                        3'b001: dec_raw = IS64 ? c_s6 : c_j;
                        3'b011: dec_raw = (c_rd == 5'd2) ? c_addi16sp : c_lui;
                        3'b100: begin
                            if (ins[11:10] == 2'b10) begin
                                dec_raw = c_s6;
                            end else if (!ins[11]) begin
                                // shamt[5] set is reserved on RV32
                                dec_raw = c_z6;
                                dec_ill = !IS64 && i12;
                            end
                        end
                        3'b101: dec_raw = c_j;
                        default: dec_raw = c_b;
                    endcase
                end
                default: begin
                    unique case (f)
                        3'b000: begin
                            dec_raw = c_z6;
                            dec_ill = !IS64 && i12;
                        end
                        3'b010: dec_raw = c_lwsp;
                        3'b001: dec_raw = c_ldsp;
                        3'b011: dec_raw = IS64 ? c_ldsp : c_lwsp;
                        3'b110: dec_raw = c_swsp;
                        3'b101: dec_raw = c_sdsp;
                        3'b111: dec_raw = IS64 ? c_sdsp : c_swsp;
                        default: ;
                    endcase
                end
            endcase
            if (ins[15:0] == 16'h0000) begin
                dec_ill = 1'b1;
            end
        end
    end

    assign dec_imm = ext32(dec_raw);

    // ------------------------------------------------------------------
    // Valid/ready holding register
    // ------------------------------------------------------------------
    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [2:0]      fmt_q, fmt_d;
    logic            ill_q, ill_d;
    logic            load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Next state: flush drops everything, otherwise load, drain or hold.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        fmt_d   = fmt_q;
        ill_d   = ill_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
            imm_d   = dec_imm;
            fmt_d   = dec_fmt;
            ill_d   = dec_ill;
        end else if (in_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register; reset clears the whole entry, including a stalled one.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            fmt_q   <= FMT_NONE;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            fmt_q   <= fmt_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_instr   = instr_q;
    assign out_pc      = pc_q;
    assign out_imm     = imm_q;
    assign out_fmt     = fmt_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Testbench for imm_decode_pipe: an RV64 and an RV32 instance share the
// same stimulus; a table of known encodings, hand-written stall/flush/reset
// sequences and a randomized run against a reference model.
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc64;
    logic [31:0] in_pc32;

    logic        rdy64, v64, ill64;
    logic [31:0] oi64;
    logic [63:0] pc64, imm64;
    logic [2:0]  fmt64;

    logic        rdy32, v32, ill32;
    logic [31:0] oi32;
    logic [31:0] pc32, imm32;
    logic [2:0]  fmt32;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign in_pc32 = in_pc64[31:0];

    imm_decode_pipe #(.XLEN(64), .EN_RVC(1'b1)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc64), .out_valid(v64), .out_ready(out_ready),
        .out_instr(oi64), .out_pc(pc64), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64)
    );

    imm_decode_pipe #(.XLEN(32), .EN_RVC(1'b1)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc32), .out_valid(v32), .out_ready(out_ready),
        .out_instr(oi32), .out_pc(pc32), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx(input logic [63:0] v, input int w);
        logic [63:0] m, r;
        m = (64'd1 << w) - 64'd1;
        r = v & m;
        if (r[w-1]) r = r | ~m;
        return r;
    endfunction

    // Scatter inst[12], inst[11], ... (n bits, MSB first) to the immediate
    // bit positions listed as hex nibbles in map; nibble F means "not used".
    function automatic logic [63:0] scat(input logic [31:0] ins, input int n,
                                         input logic [63:0] map);
        logic [63:0] r;
        logic [3:0]  d;
        r = 64'd0;
        for (int k = 0; k < n; k++) begin
            d = 4'(map >> (4 * (n - 1 - k)));
            if (d != 4'hF) r[d] = ins[12-k];
        end
        return r;
    endfunction

    function automatic void ref_dec(input logic [31:0] ins, input int xl,
                                    output logic [2:0] fmt, output logic [63:0] imm,
                                    output logic ill);
        logic [63:0] v, s6, z6, lw, ld, lwsp, ldsp, swsp, sdsp, cj;
        bit x64;
        x64  = (xl == 64);
        fmt  = 3'd0;
        ill  = 1'b0;
        v    = 64'd0;
        z6   = 64'(ins[12]) * 32 + 64'(ins[6:2]);
        s6   = sx(z6, 6);
        lw   = scat(ins, 8, 64'h543FFF26);
        ld   = scat(ins, 8, 64'h543FFF76);
        lwsp = scat(ins, 11, 64'h5FFFFF43276);
        ldsp = scat(ins, 11, 64'h5FFFFF43876);
        swsp = scat(ins, 6, 64'h543276);
        sdsp = scat(ins, 6, 64'h543876);
        cj   = sx(scat(ins, 11, 64'hB498A673215), 12);
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: begin fmt = 1; v = sx(64'(ins[31:20]), 12); end
                7'b0011011: if (x64) begin fmt = 1; v = sx(64'(ins[31:20]), 12); end
                7'b0100011: begin fmt = 2; v = sx(64'(ins[31:25]) * 32 + 64'(ins[11:7]), 12); end
                7'b1100011: begin
                    fmt = 3;
                    v = sx(64'(ins[31]) * 4096 + 64'(ins[7]) * 2048 + 64'(ins[30:25]) * 32
                           + 64'(ins[11:8]) * 2, 13);
                end
                7'b0110111, 7'b0010111: begin fmt = 4; v = sx(64'(ins[31:12]) * 4096, 32); end
                7'b1101111: begin
                    fmt = 5;
                    v = sx(64'(ins[31]) * (64'd1 << 20) + 64'(ins[19:12]) * 4096
                           + 64'(ins[20]) * 2048 + 64'(ins[30:21]) * 2, 21);
                end
                7'b1110011: if (ins[14]) begin fmt = 6; v = 64'(ins[19:15]); end
                default: ;
            endcase
        end else begin
            fmt = 7;
            case ({ins[1:0], ins[15:13]})
                5'b00_000: begin v = scat(ins, 8, 64'h54987623); ill = (v == 0); end
                5'b00_010, 5'b00_110: v = lw;
                5'b00_001, 5'b00_101: v = ld;
                5'b00_011, 5'b00_111: v = x64 ? ld : lw;
                5'b01_000, 5'b01_010: v = s6;
                5'b01_001: v = x64 ? s6 : cj;
                5'b01_011: v = (ins[11:7] == 5'd2) ? sx(scat(ins, 11, 64'h9FFFFF46875), 10)
                                                   : sx(z6 * 4096, 18);
                5'b01_100: begin
                    if (ins[11:10] == 2'b10) v = s6;
                    else if (ins[11:10] != 2'b11) begin v = z6; ill = !x64 && ins[12]; end
                end
                5'b01_101: v = cj;
                5'b01_110, 5'b01_111: v = sx(scat(ins, 11, 64'h843FFF76215), 9);
                5'b10_000: begin v = z6; ill = !x64 && ins[12]; end
                5'b10_010: v = lwsp;
                5'b10_001: v = ldsp;
                5'b10_011: v = x64 ? ldsp : lwsp;
                5'b10_110: v = swsp;
                5'b10_101: v = sdsp;
                5'b10_111: v = x64 ? sdsp : swsp;
                default: ;
            endcase
            if (ins[15:0] == 16'h0) ill = 1'b1;
        end
        if (!x64) v = v & 64'hFFFF_FFFF;
        imm = v;
    endfunction

    // ---------------- pipeline model ----------------
    logic        m_v, m_chk;
    logic [31:0] m_instr;
    logic [63:0] m_pc, m_imm64, m_imm32;
    logic [2:0]  m_fmt64, m_fmt32;
    logic        m_ill64, m_ill32;

    // One clock: check in_ready, advance the model at the edge, check outputs.
    task automatic cycle();
        logic exp_rdy;
        #1;
        exp_rdy = !m_v || out_ready;
        chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
        chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_v = 0; m_chk = 1; m_instr = 0; m_pc = 0;
            m_imm64 = 0; m_imm32 = 0; m_fmt64 = 0; m_fmt32 = 0; m_ill64 = 0; m_ill32 = 0;
        end else if (flush) begin
            m_v = 0; m_chk = 0;
        end else if (exp_rdy) begin
            if (in_valid) begin
                m_v = 1; m_chk = 1; m_instr = in_instr; m_pc = in_pc64;
                ref_dec(in_instr, 64, m_fmt64, m_imm64, m_ill64);
                ref_dec(in_instr, 32, m_fmt32, m_imm32, m_ill32);
            end else begin
                m_v = 0;
            end
        end
        #1;
        chk("out_valid64", 64'(v64), 64'(m_v));
        chk("out_valid32", 64'(v32), 64'(m_v));
        if (m_chk) begin
            chk("instr64", 64'(oi64), 64'(m_instr));
            chk("pc64", pc64, m_pc);
            chk("imm64", imm64, m_imm64);
            chk("fmt64", 64'(fmt64), 64'(m_fmt64));
            chk("ill64", 64'(ill64), 64'(m_ill64));
            chk("instr32", 64'(oi32), 64'(m_instr));
            chk("pc32", 64'(pc32), m_pc & 64'hFFFF_FFFF);
            chk("imm32", 64'(imm32), m_imm32);
            chk("fmt32", 64'(fmt32), 64'(m_fmt32));
            chk("ill32", 64'(ill32), 64'(m_ill32));
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        bit          is32;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops[9] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h73};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: r[6:0] = ops[$urandom_range(0, 8)];
            2: if (r[1:0] == 2'b11) r[1:0] = 2'($urandom_range(0, 2));
            default: begin
                r[15:0] = 16'($urandom) & 16'hE003;
                if (r[1:0] == 2'b11) r[1:0] = 2'b01;
                if ($urandom_range(0, 1) == 1) r[12] = 1'b1;
                if ($urandom_range(0, 1) == 1) r[11:7] = 5'd2;
            end
        endcase
        return r;
    endfunction

    localparam logic [31:0] INS_A = 32'hFFF00093;
    localparam logic [31:0] INS_B = 32'h300FD073;

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_instr = 0; in_pc64 = 0;
        m_v = 0; m_chk = 0; m_instr = 0; m_pc = 0;
        m_imm64 = 0; m_imm32 = 0; m_fmt64 = 0; m_fmt32 = 0; m_ill64 = 0; m_ill32 = 0;

        // Reset state
        cycle();
        cycle();
        chk("rst_valid", 64'(v64), 64'd0);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_fmt", 64'(fmt64), 64'd0);
        chk("rst_ill", 64'(ill64), 64'd0);
        rst = 0;

        // Known encodings
        tbl.push_back('{32'hFFF00093, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
        tbl.push_back('{32'hFE000EE3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0});
        tbl.push_back('{32'h300FD073, 1'b0, 64'h1F, 3'd6, 1'b0});
        tbl.push_back('{32'h0000_50FD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 1'b0});
        tbl.push_back('{32'h0000_0000, 1'b0, 64'h0, 3'd7, 1'b1});
        tbl.push_back('{32'h0000_0004, 1'b0, 64'h0, 3'd7, 1'b1});
        tbl.push_back('{32'h800000B7, 1'b0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0});
        tbl.push_back('{32'h0010009B, 1'b0, 64'h1, 3'd1, 1'b0});
        tbl.push_back('{32'h0020A423, 1'b0, 64'h8, 3'd2, 1'b0});
        tbl.push_back('{32'hFFDFF0EF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0});
        tbl.push_back('{32'h0000_1006, 1'b0, 64'h21, 3'd7, 1'b0});
        tbl.push_back('{32'h00000073, 1'b0, 64'h0, 3'd0, 1'b0});
        tbl.push_back('{32'h800000B7, 1'b1, 64'h8000_0000, 3'd4, 1'b0});
        tbl.push_back('{32'h0010009B, 1'b1, 64'h0, 3'd0, 1'b0});
        tbl.push_back('{32'h0000_1006, 1'b1, 64'h21, 3'd7, 1'b1});
        tbl.push_back('{32'hFFF00093, 1'b1, 64'hFFFF_FFFF, 3'd1, 1'b0});

        foreach (tbl[i]) begin
            in_valid = 1; out_ready = 1; in_instr = tbl[i].ins;
            in_pc64 = {$urandom, $urandom};
            cycle();
            if (tbl[i].is32) begin
                chk($sformatf("tbl%0d_imm32", i), 64'(imm32), tbl[i].imm);
                chk($sformatf("tbl%0d_fmt32", i), 64'(fmt32), 64'(tbl[i].fmt));
                chk($sformatf("tbl%0d_ill32", i), 64'(ill32), 64'(tbl[i].ill));
            end else begin
                chk($sformatf("tbl%0d_imm64", i), imm64, tbl[i].imm);
                chk($sformatf("tbl%0d_fmt64", i), 64'(fmt64), 64'(tbl[i].fmt));
                chk($sformatf("tbl%0d_ill64", i), 64'(ill64), 64'(tbl[i].ill));
            end
        end

        // Stall with B offered, then release
        in_valid = 1; out_ready = 1; in_instr = INS_A;
        cycle();
        in_instr = INS_B; out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_ready", 64'(rdy64), 64'd0);
            chk("stall_instr", 64'(oi64), 64'(INS_A));
            chk("stall_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        out_ready = 1;
        cycle();
        chk("release_instr", 64'(oi64), 64'(INS_B));
        chk("release_imm", imm64, 64'h1F);

        // Flush during a stall
        in_instr = INS_A;
        cycle();
        in_instr = INS_B; out_ready = 0;
        cycle();
        flush = 1;
        cycle();
        chk("flush_valid", 64'(v64), 64'd0);
        flush = 0; in_valid = 0;
        cycle();
        chk("flush_nocapture", 64'(v64), 64'd0);

        // Reset during a stall
        in_valid = 1; out_ready = 1; in_instr = INS_A;
        cycle();
        in_instr = INS_B; out_ready = 0;
        cycle();
        rst = 1;
        cycle();
        chk("rststall_valid", 64'(v64), 64'd0);
        chk("rststall_imm", imm64, 64'd0);
        rst = 0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            in_instr  = rand_instr();
            in_pc64   = {$urandom, $urandom};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
